// File: rtl/reqack_initiator.sv
// reqack_initiator: initiator side of the req/ack/done/intrpt handshake.
// Issues one req per host start and checks the responder reply timing.
module reqack_initiator #(
  parameter int MAX_ACK  = 5,
  parameter int INTR_WIN = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             ack,
  input  logic             done,
  input  logic             intrpt,
  output logic             req,
  output logic             busy,
  output logic             xfer_ok,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_ACK  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_INT  = 3'd4;

  localparam logic [2:0] C_ACK_TO   = 3'd1;
  localparam logic [2:0] C_NO_DONE  = 3'd2;
  localparam logic [2:0] C_ACK_DONE = 3'd3;
  localparam logic [2:0] C_INT_TO   = 3'd4;
  localparam logic [2:0] C_SPUR     = 3'd5;

  // One counter serves both the ack window and the interrupt window.
  localparam int KW = $clog2(MAX_ACK + INTR_WIN + 2);
  localparam logic [KW-1:0] K_ACK = KW'(MAX_ACK);
  localparam logic [KW-1:0] K_INT = KW'(INTR_WIN);
  localparam logic [KW-1:0] K_ONE = KW'(1);

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [KW-1:0] k;
  logic [KW-1:0] k_n;
  logic          ok_n;
  logic          err_n;
  logic [2:0]    code_n;

  // Next-state, window counting and outcome decode.
  always_comb begin
    state_n = state;
    k_n     = k;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    code_n  = err_code;
    case (state)
      S_IDLE: begin
        if (ack || done) begin
          err_n  = 1'b1;
          code_n = C_SPUR;
        end else if (start) begin
          state_n = S_REQ;
          code_n  = 3'd0;
        end
      end
      S_REQ: begin
        state_n = S_ACK;
        k_n     = K_ONE;
      end
      S_ACK: begin
        if (ack) begin
          state_n = S_DONE;
        end else if (done) begin
          err_n  = 1'b1;
          code_n = C_NO_DONE;
        end else if (k == K_ACK) begin
          err_n  = 1'b1;
          code_n = C_ACK_TO;
        end else begin
          k_n = k + K_ONE;
        end
      end
      S_DONE: begin
        if (done && ack) begin
          err_n  = 1'b1;
          code_n = C_ACK_DONE;
        end else if (!done) begin
          err_n  = 1'b1;
          code_n = C_NO_DONE;
        end else if (intrpt) begin
          ok_n = 1'b1;
        end else if (INTR_WIN == 0) begin
          err_n  = 1'b1;
          code_n = C_INT_TO;
        end else begin
          state_n = S_INT;
          k_n     = K_ONE;
        end
      end
      S_INT: begin
        if (!intrpt && k == K_INT) begin
          err_n  = 1'b1;
          code_n = C_INT_TO;
        end else if (ack || done) begin
          err_n  = 1'b1;
          code_n = C_SPUR;
        end else if (intrpt) begin
          ok_n = 1'b1;
        end else begin
          k_n = k + K_ONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (ok_n || err_n) state_n = S_IDLE;
  end

  // State, registered outputs and the success counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      k        <= '0;
      req      <= 1'b0;
      busy     <= 1'b0;
      xfer_ok  <= 1'b0;
      err      <= 1'b0;
      err_code <= 3'd0;
      xfer_cnt <= '0;
    end else begin
      state    <= state_n;
      k        <= k_n;
      req      <= (state_n == S_REQ);
      busy     <= (state_n != S_IDLE);
      xfer_ok  <= ok_n;
      err      <= err_n;
      err_code <= code_n;
      if (ok_n) xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_reqack_initiator.sv
// tb_reqack_initiator: table-driven transfers plus corner sequences,
// outcomes checked through an expected-result queue.
module tb_reqack_initiator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        ack = 1'b0;
  logic        done = 1'b0;
  logic        intrpt = 1'b0;
  logic        req;
  logic        busy;
  logic        xfer_ok;
  logic        err;
  logic [2:0]  err_code;
  logic [15:0] xfer_cnt;

  reqack_initiator #(
    .MAX_ACK(5), .INTR_WIN(3), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .ack(ack), .done(done), .intrpt(intrpt),
    .req(req), .busy(busy), .xfer_ok(xfer_ok),
    .err(err), .err_code(err_code), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a0; int a1;
    int d0; int d1;
    int i0; int i1;
    bit ok; int code; int at;
  } vec_t;

  typedef struct {
    bit ok; int code; int at; int cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   cnt_m = 0;

  function automatic void chk(string name, int act, int req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && (xfer_ok || err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, xfer_ok, err}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", {30'd0, xfer_ok, err},
            {30'd0, e.ok, !e.ok});
        chk("pulse_cycle", cyc, e.at);
        chk("err_code", int'(err_code), e.code);
        chk("xfer_cnt", int'(xfer_cnt), e.cnt);
        chk("busy_at_pulse", int'(busy), 0);
      end
    end
  end

  task automatic push_exp(bit ok, int code, int at);
    exp_t e;
    if (ok) cnt_m = (cnt_m + 1) & 16'hFFFF;
    e.ok = ok; e.code = code; e.at = at; e.cnt = cnt_m;
    sb.push_back(e);
  endtask

  task automatic drain(string name);
    for (int w = 0; w < 6 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() > 0) begin
      chk(name, sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run_vec(vec_t v, string name);
    int r;
    @(negedge clk);
    start = 1'b1;
    r = cyc + 1;
    push_exp(v.ok, v.code, r + v.at);
    @(negedge clk);
    start = 1'b0;
    chk({name, "_req"}, int'(req), 1);
    chk({name, "_busy"}, int'(busy), 1);
    for (int t = 0; t <= 12; t++) begin
      if (t == 1) chk({name, "_req_low"}, int'(req), 0);
      ack    = (t >= v.a0 && t <= v.a1);
      done   = (t >= v.d0 && t <= v.d1);
      intrpt = (t >= v.i0 && t <= v.i1);
      @(negedge clk);
    end
    ack = 1'b0; done = 1'b0; intrpt = 1'b0;
    drain({name, "_timeout"});
  endtask

  vec_t tbl[12];
  string nm[12];

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt;
    int last_r;
    tbl[0]  = '{3, 3, 4, 4, 6, 6, 1, 0, 7};      nm[0]  = "nominal";
    tbl[1]  = '{1, 1, 2, 2, 2, 2, 1, 0, 3};      nm[1]  = "fastest";
    tbl[2]  = '{5, 5, 6, 6, 9, 9, 1, 0, 10};     nm[2]  = "slowest";
    tbl[3]  = '{-1, -1, -1, -1, -1, -1, 0, 1, 6}; nm[3] = "ack_to";
    tbl[4]  = '{2, 2, 3, 3, 7, 7, 0, 4, 7};      nm[4]  = "int_to";
    tbl[5]  = '{2, 2, -1, -1, -1, -1, 0, 2, 4};  nm[5]  = "no_done";
    tbl[6]  = '{2, 3, 3, 3, -1, -1, 0, 3, 4};    nm[6]  = "ack_w_done";
    tbl[7]  = '{-1, -1, 2, 2, -1, -1, 0, 2, 3};  nm[7]  = "done_early";
    tbl[8]  = '{1, 1, 2, 3, -1, -1, 0, 5, 4};    nm[8]  = "spur_int";
    tbl[9]  = '{0, 0, -1, -1, -1, -1, 0, 1, 6};  nm[9]  = "ack_in_req";
    tbl[10] = '{1, 1, 2, 2, 0, 1, 0, 4, 6};      nm[10] = "early_int";
    tbl[11] = '{4, 4, 5, 5, 6, 6, 1, 0, 7};      nm[11] = "int_d1";

    #3 reset_n = 1'b0;
    #1;
    chk("rst_req", int'(req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ok", int'(xfer_ok), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_code", int'(err_code), 0);
    chk("rst_cnt", int'(xfer_cnt), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(tbl[i], nm[i]);

    @(negedge clk);
    done = 1'b1;
    push_exp(1'b0, 5, cyc + 1);
    @(negedge clk);
    done = 1'b0;
    chk("spur_idle_busy0", int'(busy), 0);
    @(negedge clk);
    chk("spur_idle_busy1", int'(busy), 0);
    drain("spur_idle_timeout");

    start = 1'b1;
    nxt = cyc + 1;
    last_r = -100;
    for (int i = 0; i < 20; i++) begin
      chk("b2b_req", int'(req), int'(cyc == nxt));
      if (req) begin
        last_r = cyc;
        nxt = cyc + 4;
        push_exp(1'b1, 0, cyc + 3);
      end
      if (i == 15) begin
        start = 1'b0;
        if (nxt > cyc) nxt = -1;
      end
      ack    = (cyc == last_r + 1);
      done   = (cyc == last_r + 2);
      intrpt = (cyc == last_r + 2);
      @(negedge clk);
    end
    ack = 1'b0; done = 1'b0; intrpt = 1'b0;
    drain("b2b_timeout");

    @(negedge clk);
    force dut.xfer_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.xfer_cnt;
    cnt_m = 16'hFFFF;
    run_vec(tbl[0], "wrap");
    chk("wrap_cnt", int'(xfer_cnt), 0);

    run_vec(tbl[6], "pre_rst_err");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("mid_busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", int'(req), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ok", int'(xfer_ok), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_code", int'(err_code), 0);
    chk("mid_rst_cnt", int'(xfer_cnt), 0);
    cnt_m = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_vec(tbl[0], "post_rst");
    chk("post_rst_cnt", int'(xfer_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reqack_initiator.md
# reqack_initiator

Initiator side of the req/ack/done/intrpt handshake. On a host `start` pulse it issues a one-cycle `req` and checks the responder's reply. The responder must give `ack` within `MAX_ACK` cycles, then `done` exactly one cycle later with `ack` low, then `intrpt` within `INTR_WIN` cycles of `done`. The block sits between a host sequencer and any responder implementing that protocol. It reports success or a coded error per transfer and counts good transfers.

## Interface
- `MAX_ACK`, 5, last cycle after the `req` cycle at which `ack` is accepted (≥1)
- `INTR_WIN`, 3, last cycle after the `done` cycle at which `intrpt` is accepted (≥0)
- `CNT_W`, 16, width of `xfer_cnt`
- `clk`  in  1  clock; all logic on posedge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  host request to begin a transfer; sampled only in IDLE
- `ack`  in  1  responder acknowledge
- `done`  in  1  responder completion
- `intrpt`  in  1  responder interrupt
- `req`  out  1  request to responder; one-cycle pulse
- `busy`  out  1  transfer in progress
- `xfer_ok`  out  1  one-cycle pulse: transfer completed correctly
- `err`  out  1  one-cycle pulse: protocol violation detected
- `err_code`  out  3  cause of last error; held until next accepted `start`
- `xfer_cnt`  out  CNT_W  count of successful transfers, wraps modulo 2^CNT_W

## Operation
- All outputs are registered. Reset value of every output is 0. Asynchronous reset forces IDLE and drops `req` and `busy` immediately, even mid-transfer.
- State machine: IDLE → REQ → WAIT_ACK → WAIT_DONE → WAIT_INT → IDLE. Any error returns to IDLE.
- IDLE
  - `start`=1 → REQ, and clears `err_code` to 0.
  - `ack` or `done` high here → `err`, code 5 SPURIOUS; state unchanged.
  - `start` is ignored in every other state.
- REQ (cycle R)
  - `req`=1 and `busy`=1; go to WAIT_ACK.
  - `ack`/`done` in cycle R are not accepted.
- WAIT_ACK
  - An internal counter k runs 1..MAX_ACK over cycles R+1..R+MAX_ACK.
  - `ack`=1 at cycle A → WAIT_DONE.
  - No `ack` by cycle R+MAX_ACK → code 1 ACK_TO.
  - `done` without `ack` → code 2 NO_DONE.
- WAIT_DONE (cycle A+1)
  - `done`=1 and `ack`=0 → WAIT_INT (cycle D = A+1).
  - `done`=1 and `ack`=1 → code 3 ACK_WITH_DONE.
  - `done`=0 → code 2 NO_DONE.
- WAIT_INT window covers cycles D..D+INTR_WIN, inclusive of D.
  - `intrpt` sampled in cycle D itself counts. Checking happens in the WAIT_DONE evaluation when `done`=1, `ack`=0 and `intrpt`=1 are all seen together.
  - `intrpt`=1 at cycle I → success.
  - No `intrpt` by D+INTR_WIN → code 4 INT_TO.
  - `ack` or `done` in cycles after D → code 5 SPURIOUS.
- Success
  - `xfer_ok` pulses and `xfer_cnt` increments by 1; FFFF wraps to 0000.
- Error
  - `err` pulses, `err_code` is loaded, `xfer_cnt` is unchanged.
- Simultaneous detections: priority is 3 > 2 > 1 > 4 > 5.
- Only one transfer is outstanding at a time; `req` never asserts while `busy` is already high from a previous transfer.

## Timing
- `start` high at edge E → `req`=1 and `busy`=1 in the cycle after E (cycle R); `req` low from R+1.
- Outcome pulse (`xfer_ok` or `err`) is high for exactly one cycle, starting the cycle after the deciding sample:
  - success: cycle I+1
  - ACK_TO: cycle R+MAX_ACK+1
  - NO_DONE, ACK_WITH_DONE: cycle A+2
  - INT_TO: cycle D+INTR_WIN+1
- `busy` falls in the same cycle the outcome pulse rises.
- A `start` sampled in that cycle is accepted, giving back-to-back `req` with one idle cycle between them.
- `xfer_cnt` and `err_code` update in the same cycle as their pulse.
- Fastest transfer: ack at R+1, done with intrpt at R+2 → `xfer_ok` at R+3.
- Slowest successful transfer: `xfer_ok` at R+MAX_ACK+INTR_WIN+2.

## Test plan
- Nominal: start; ack at R+3; done at R+4; intrpt at R+6 → `xfer_ok` at R+7, `xfer_cnt`=1, `err` never high.
- Window edges:
  - ack at R+5 with intrpt at D+3 → success.
  - ack at R+6 → `err` at R+6, code 1.
  - intrpt at D+4 → `err` at D+4, code 4.
- Done faults:
  - ack at R+2, done low at R+3 → `err` at R+4, code 2.
  - ack and done both high at R+3 → code 3 at R+4.
- Spurious and overlap:
  - done pulse in IDLE → `err`, code 5, `busy` stays 0.
  - start during `busy` → no second `req`, counter unaffected.
- Back-to-back and wrap:
  - preload `xfer_cnt` to FFFF via 65535 transfers, or force in the bench; one success → 0000.
  - start held high → `req` every transfer with one idle cycle gap.
- Reset mid-transfer: deassert `reset_n` in WAIT_INT → all outputs 0 asynchronously; after release, start → normal transfer with `xfer_cnt`=1.
